// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared encodings for the data memory unit: access sizes,
//                response error bit positions, FSM states and parameter
//                legality helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] c_size_byte   = 2'b00;
    localparam logic [1:0] c_size_half   = 2'b01;
    localparam logic [1:0] c_size_word   = 2'b10;
    localparam logic [1:0] c_size_double = 2'b11;

    // Bit positions inside rsp_err
    localparam int c_err_misalign = 0;
    localparam int c_err_range    = 1;

    // Controller states: clear the array after reset, then serve requests
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Only 32- and 64-bit data paths are supported
    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    // Depth must be a power of two with at least 16 words
    function automatic bit depth_legal(input int depth);
        return (depth >= 16) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_align
//  Description : Combinational load lane select. Shifts the addressed bytes
//                down to bit 0, masks to the access size and sign- or
//                zero-extends to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_align
    import data_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]               i_word,
    input  logic [$clog2(XLEN/8)-1:0]     i_offset,
    input  logic [1:0]                    i_size,
    input  logic                          i_unsigned,
    output logic [XLEN-1:0]               o_data
);

    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_mask;
    logic            w_sign;

    // Bring the first addressed byte down to lane 0
    assign w_shifted = i_word >> {i_offset, 3'b000};

    // Mask to access size and fill the upper bits with the extension bit
    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (i_size)
            c_size_byte: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_shifted[7];
            end
            c_size_half: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            c_size_word: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
        o_data = (w_shifted & w_mask) | ({XLEN{w_sign & ~i_unsigned}} & ~w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_unit
//  Description : Single-port byte-addressable data memory with sized loads
//                and stores, fault detection and a one-word-per-cycle clear
//                sequence after reset. One response per accepted request,
//                one cycle after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            busy
);

    localparam int c_nb    = XLEN / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_idx_w = $clog2(DEPTH);

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("data_mem_unit: XLEN must be 32 or 64");
        end
        if (!depth_legal(DEPTH)) begin : g_bad_depth
            $error("data_mem_unit: DEPTH must be a power of two >= 16");
        end
    endgenerate

    // Control
    state_t               r_state;
    state_t               w_state_next;
    logic [c_idx_w-1:0]   r_clr_idx;
    logic                 w_run;
    logic                 w_accept;

    // Request decode
    logic [c_off_w-1:0]   w_offset;
    logic [2:0]           w_off3;
    logic [c_idx_w-1:0]   w_word_idx;
    logic                 w_oor;
    logic                 w_mis;
    logic                 w_fault;
    logic [1:0]           w_err;
    logic [c_nb-1:0]      w_size_strb;
    logic [c_nb-1:0]      w_strb;
    logic [XLEN-1:0]      w_wdata_shift;

    // Array write port
    logic [c_nb-1:0]      w_wr_en;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic [XLEN-1:0]      w_wr_data;
    logic [XLEN-1:0]      r_mem [DEPTH];

    // Response pipeline
    logic                 r_rsp_valid;
    logic                 r_rsp_load;
    logic [1:0]           r_rsp_err;
    logic [XLEN-1:0]      r_rd_word;
    logic [c_off_w-1:0]   r_rd_off;
    logic [1:0]           r_rd_size;
    logic                 r_rd_unsigned;
    logic [XLEN-1:0]      w_load_data;

    // Reset is folded into the handshake so nothing is accepted or reported
    // while it is asserted, even before the first reset edge.
    assign req_ready = w_run & ~reset;
    assign busy      = ~w_run | reset;
    assign w_accept  = req_valid & req_ready;

    // Address split: byte offset, word index, then range bits above
    assign w_offset   = req_addr[c_off_w-1:0];
    assign w_off3     = 3'(w_offset);
    assign w_word_idx = req_addr[c_off_w +: c_idx_w];
    assign w_oor      = |(req_addr >> (c_off_w + c_idx_w));
    assign w_fault    = w_oor | w_mis;

    // Alignment check and size-to-strobe mapping
    always_comb begin
        w_mis       = 1'b0;
        w_size_strb = '1;
        case (req_size)
            c_size_byte: begin
                w_mis       = 1'b0;
                w_size_strb = c_nb'(8'h01);
            end
            c_size_half: begin
                w_mis       = w_off3[0];
                w_size_strb = c_nb'(8'h03);
            end
            c_size_word: begin
                w_mis       = |w_off3[1:0];
                w_size_strb = c_nb'(8'h0F);
            end
            default: begin
                w_mis       = (XLEN == 32) || (|w_off3);
                w_size_strb = '1;
            end
        endcase
    end

    // Error vector built from the shared bit positions
    always_comb begin
        w_err                 = '0;
        w_err[c_err_range]    = w_oor;
        w_err[c_err_misalign] = w_mis;
    end

    assign w_strb        = w_size_strb << w_offset;
    assign w_wdata_shift = req_wdata << {w_offset, 3'b000};

    // Write port arbitration: clear sequence owns the port in CLEAR
    always_comb begin
        w_wr_en   = '0;
        w_wr_idx  = w_word_idx;
        w_wr_data = w_wdata_shift;
        if (r_state == ST_CLEAR) begin
            w_wr_en   = '1;
            w_wr_idx  = r_clr_idx;
            w_wr_data = '0;
        end else if (w_accept && req_write && !w_fault) begin
            w_wr_en   = w_strb;
        end
    end

    // Byte-strobed array write
    always_ff @(posedge clk) begin
        for (int b = 0; b < c_nb; b++) begin
            if (w_wr_en[b]) begin
                r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    // State register and clear index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // Next-state: leave CLEAR once the last word has been written
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_idx == c_idx_w'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    // Response control: valid pulse, error code, load-data enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_rsp_err   <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_load  <= w_accept & ~req_write & ~w_fault;
            r_rsp_err   <= w_accept ? w_err : 2'b00;
        end
    end

    // Array read and load attributes captured at the accept edge
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd_word     <= r_mem[w_word_idx];
            r_rd_off      <= w_offset;
            r_rd_size     <= req_size;
            r_rd_unsigned <= req_unsigned;
        end
    end

    dmem_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_word     (r_rd_word),
        .i_offset   (r_rd_off),
        .i_size     (r_rd_size),
        .i_unsigned (r_rd_unsigned),
        .o_data     (w_load_data)
    );

    assign rsp_valid = r_rsp_valid & ~reset;
    assign rsp_err   = reset ? 2'b00 : r_rsp_err;
    assign rsp_rdata = (r_rsp_load & ~reset) ? w_load_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_unit
//  Description : Scoreboard bench for data_mem_unit (XLEN=64, DEPTH=1024).
//                A byte-array reference model predicts each response at
//                issue time; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 1024;
    localparam int c_bytes = DEPTH * 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;

    data_mem_unit #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  err;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  mdl [c_bytes];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < c_bytes; i++) mdl[i] = 8'h00;
    endfunction

    // Issue one request. Expected response comes from the byte model unless
    // explicit constants are supplied; the model is updated either way.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input bit use_exp, input logic [63:0] e_rd, input logic [1:0] e_err);
        int          nb;
        int          base;
        int          waitc;
        logic        oor;
        logic        mis;
        logic [63:0] v;
        exp_t        e;
        nb   = 1 << sz;
        oor  = (addr >> 13) != 64'd0;
        mis  = (addr % 64'(nb)) != 64'd0;
        base = int'(addr[12:0]);
        v    = '0;
        if (!oor && !mis) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mdl[base + i] = 8'(wd >> (8 * i));
            end else begin
                for (int i = 0; i < nb; i++) v = v | (64'(mdl[base + i]) << (8 * i));
                if (!uns && nb < 8 && v[8 * nb - 1]) v = v | (~64'd0 << (8 * nb));
            end
        end
        if (use_exp) begin
            e.rd  = e_rd;
            e.err = e_err;
        end else begin
            e.rd  = v;
            e.err = {oor, mis};
        end
        waitc = 0;
        while (!req_ready && waitc < 4000) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual req_ready=0 required=1");
        end
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Hold reset, check quiescent outputs, release and time the clear phase
    task automatic do_reset(input int hold);
        int n;
        bit rdy_bad;
        reset     = 1'b1;
        req_valid = 1'b0;
        q.delete();
        model_clear();
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err",   64'(rsp_err), 64'd0);
        chk("reset_busy",      64'(busy), 64'd1);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        n       = 0;
        rdy_bad = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            if (!busy) break;
            if (req_ready) rdy_bad = 1'b1;
            n++;
        end
        chk("clear_cycles", 64'(n), 64'd1024);
        chk("ready_during_clear", 64'(rdy_bad), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual rsp_valid=1 required=0");
            end else begin
                mon_e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rd);
                chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(3);

        // Directed sequence on a freshly cleared array
        issue(1'b0, 2'b11, 1'b0, 64'h1FF8, 64'h0, 1, 64'h0, 2'b00);
        issue(1'b1, 2'b11, 1'b0, 64'h10, 64'h0123456789ABCDEF, 1, 64'h0, 2'b00);
        issue(1'b0, 2'b00, 1'b0, 64'h17, 64'h0, 1, 64'h0000000000000001, 2'b00);
        issue(1'b0, 2'b00, 1'b1, 64'h10, 64'h0, 1, 64'h00000000000000EF, 2'b00);
        issue(1'b0, 2'b01, 1'b0, 64'h10, 64'h0, 1, 64'hFFFFFFFFFFFFCDEF, 2'b00);
        issue(1'b0, 2'b10, 1'b1, 64'h14, 64'h0, 1, 64'h0000000001234567, 2'b00);
        issue(1'b1, 2'b00, 1'b0, 64'h11, 64'h80, 1, 64'h0, 2'b00);
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 1, 64'h0123456789AB80EF, 2'b00);
        issue(1'b0, 2'b10, 1'b0, 64'h12, 64'h0, 1, 64'h0, 2'b01);
        issue(1'b1, 2'b11, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, 2'b10);
        issue(1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 1, 64'h0, 2'b00);
        issue(1'b0, 2'b10, 1'b0, 64'h2002, 64'h0, 1, 64'h0, 2'b11);

        // Randomized traffic, clustered so loads revisit stored words
        for (int k = 0; k < 400; k++) begin
            logic [63:0] a;
            logic [1:0]  sz;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) a = 64'($urandom) & 64'h1FFF;
            if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            if ($urandom_range(0, 11) == 0) a = a | (64'd1 << $urandom_range(13, 63));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, 0, 64'h0, 2'b00);
        end

        // Reset during a response cycle: the response must be dropped
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, 64'h0, 2'b00);
        do_reset(2);

        // Store, then reset part-way through a clear
        issue(1'b1, 2'b11, 1'b0, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1, 64'h0, 2'b00);
        issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 1, 64'hDEAD_BEEF_CAFE_F00D, 2'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        do_reset(1);
        issue(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 1, 64'h0, 2'b00);
        issue(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 1, 64'h0, 2'b00);

        repeat (4) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
